// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged active-low domain reset sequencer with request handshake
// Optional build macro: RST_SEQ_LOCK_EN (requests are ignored while a sequence is in progress).
module rst_seq_ctrl #(
  parameter int NUM_DOM    = 3,
  parameter int ASSERT_CYC = 16,
  parameter int STEP_CYC   = 4,
  parameter int CNT_W      = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_RST,
  output logic               REQ_ACK,
  output logic [NUM_DOM-1:0] DOM_RST_N,
  output logic               BUSY,
  output logic               SEQ_DONE
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               done_q, done_d;
  logic               req_q, req_d;
  logic               req_edge;
  logic               accept;

  // Next-state logic: a request restarts the sequence, otherwise step the release schedule.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dom_d    = dom_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    req_d    = REQ_RST;
    req_edge = REQ_RST & ~req_q;
`ifdef RST_SEQ_LOCK_EN
    accept   = req_edge & ~busy_q;
`else
    accept   = req_edge;
`endif

    if (accept) begin
      // Request wins even against the final release, so no stale SEQ_DONE escapes.
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      busy_d  = 1'b1;
      ack_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dom_d  = '1;
          busy_d = 1'b0;
        end
        ST_ASSERT: begin
          dom_d  = '0;
          busy_d = 1'b1;
          if (cnt_q == ASSERT_LAST) begin
            dom_d[0] = 1'b1;
            cnt_d    = '0;
            if (NUM_DOM == 1) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_DOM; i++) begin
              if (IDX_W'(i) == idx_q) begin
                dom_d[i] = 1'b1;
              end
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; the edge register resets high so a held request is not an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      req_q   <= req_d;
    end
  end

  assign REQ_ACK   = ack_q;
  assign DOM_RST_N = dom_q;
  assign BUSY      = busy_q;
  assign SEQ_DONE  = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - randomized self-checking bench for rst_seq_ctrl against a timeline model
module tb_rst_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_RST = 1'b0;
  logic       ack0, busy0, done0;
  logic [2:0] dom0;
  logic       ack1, busy1, done1;
  logic [0:0] dom1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rst_seq_ctrl #(.NUM_DOM(3), .ASSERT_CYC(16), .STEP_CYC(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .REQ_RST(REQ_RST), .REQ_ACK(ack0),
    .DOM_RST_N(dom0), .BUSY(busy0), .SEQ_DONE(done0)
  );

  rst_seq_ctrl #(.NUM_DOM(1), .ASSERT_CYC(1), .STEP_CYC(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .REQ_RST(REQ_RST), .REQ_ACK(ack1),
    .DOM_RST_N(dom1), .BUSY(busy1), .SEQ_DONE(done1)
  );

  // Model: each instance is described by cycles elapsed since its sequence began.
  int m_n [2] = '{3, 1};
  int m_a [2] = '{16, 1};
  int m_s [2] = '{4, 1};
  int m_e [2] = '{0, 0};
  bit m_ack [2] = '{1'b0, 1'b0};
  bit m_rq [2] = '{1'b1, 1'b1};

  function automatic int t_end(input int i);
    return m_a[i] + (m_n[i] - 1) * m_s[i];
  endfunction

  function automatic int exp_dom(input int i);
    int v = 0;
    for (int k = 0; k < m_n[i]; k++)
      if (m_e[i] >= m_a[i] + k * m_s[i]) v |= (1 << k);
    return v;
  endfunction

  task automatic model_step(input bit r, input bit q);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_e[i] = 0; m_ack[i] = 1'b0; m_rq[i] = 1'b1;
      end else begin
        bit edge_seen = q & ~m_rq[i];
        bit acc = edge_seen;
        bit busy_now = (m_e[i] < t_end(i));
        m_rq[i] = q;
`ifdef RST_SEQ_LOCK_EN
        acc = edge_seen & ~busy_now;
`endif
        if (busy_now && !acc) begin end
        if (acc) begin
          m_e[i] = 0; m_ack[i] = 1'b1;
        end else begin
          m_ack[i] = 1'b0;
          if (m_e[i] <= t_end(i)) m_e[i]++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("dom0", int'(dom0), exp_dom(0));
    chk("busy0", int'(busy0), int'(m_e[0] < t_end(0)));
    chk("ack0", int'(ack0), int'(m_ack[0]));
    chk("done0", int'(done0), int'(m_e[0] == t_end(0)));
    chk("dom1", int'(dom1), exp_dom(1));
    chk("busy1", int'(busy1), int'(m_e[1] < t_end(1)));
    chk("ack1", int'(ack1), int'(m_ack[1]));
    chk("done1", int'(done1), int'(m_e[1] == t_end(1)));
  endtask

  // Drive inputs at a falling edge, advance the model past the rising edge, compare at the next falling edge.
  task automatic tick(input bit r, input bit q);
    RST = r;
    REQ_RST = q;
    model_step(r, q);
    @(negedge CLK);
    compare_all();
  endtask

  int acks;
  int dones;

  initial begin
    @(negedge CLK);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("reset_dom0", int'(dom0), 0);
    chk("reset_busy0", int'(busy0), 1);
    chk("reset_ack0", int'(ack0), 0);
    chk("reset_done0", int'(done0), 0);

    // Scenario 1 and 6 (after reset): literal release timeline.
    for (int j = 1; j <= 30; j++) begin
      tick(1'b0, 1'b0);
      if (j == 1) begin
        chk("n1_c1_dom", int'(dom1), 1);
        chk("n1_c1_done", int'(done1), 1);
      end
      if (j == 15) chk("c15_dom", int'(dom0), 0);
      if (j == 16) chk("c16_dom", int'(dom0), 1);
      if (j == 20) chk("c20_dom", int'(dom0), 3);
      if (j == 23) chk("c23_busy", int'(busy0), 1);
      if (j == 24) begin
        chk("c24_dom", int'(dom0), 7);
        chk("c24_done", int'(done0), 1);
        chk("c24_busy", int'(busy0), 0);
      end
      if (j == 25) chk("c25_done", int'(done0), 0);
    end

    // Scenario 2 and 6: request from IDLE.
    tick(1'b0, 1'b1);
    chk("req_ack", int'(ack0), 1);
    chk("req_dom", int'(dom0), 0);
    chk("req_busy", int'(busy0), 1);
    chk("n1_req_ack", int'(ack1), 1);
    tick(1'b0, 1'b0);
    chk("req_ack_once", int'(ack0), 0);
    chk("n1_rel_dom", int'(dom1), 1);
    chk("n1_rel_done", int'(done1), 1);
    for (int j = 3; j <= 25; j++) tick(1'b0, 1'b0);
    chk("req_t25_dom", int'(dom0), 7);
    chk("req_t25_done", int'(done0), 1);

    // Scenario 3: request held high for 60 cycles.
    acks = 0; dones = 0;
    for (int j = 0; j < 60; j++) begin
      tick(1'b0, 1'b1);
      acks += int'(ack0);
      dones += int'(done0);
    end
    chk("held_acks", acks, 1);
    chk("held_dones", dones, 1);
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b1);
    acks = 0;
    for (int j = 0; j < 30; j++) begin
      tick(1'b0, 1'b1);
      acks += int'(ack0);
    end
    chk("held_thru_reset_acks", acks, 0);

    // Scenario 4: new request edge while 011.
    tick(1'b0, 1'b0);
    for (int j = 0; j < 21; j++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b0);
    for (int j = 1; j <= 21; j++) tick(1'b0, 1'b0);
    chk("pre_abort_dom", int'(dom0), 3);
    tick(1'b0, 1'b1);
`ifdef RST_SEQ_LOCK_EN
    chk("abort_ack", int'(ack0), 0);
`else
    chk("abort_ack", int'(ack0), 1);
    chk("abort_dom", int'(dom0), 0);
`endif
    for (int j = 0; j < 30; j++) tick(1'b0, 1'b0);

    // Scenario 5: reset while 001.
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b0);
    for (int j = 1; j <= 17; j++) tick(1'b0, 1'b0);
    chk("pre_rst_dom", int'(dom0), 1);
    tick(1'b1, 1'b0);
    chk("mid_rst_dom", int'(dom0), 0);
    chk("mid_rst_busy", int'(busy0), 1);
    chk("mid_rst_done", int'(done0), 0);
    for (int j = 1; j <= 24; j++) tick(1'b0, 1'b0);
    chk("after_rst_c24_dom", int'(dom0), 7);
    chk("after_rst_c24_done", int'(done0), 1);

    // Randomized phase: sparse request toggles and occasional reset pulses.
    for (int j = 0; j < 3000; j++) begin
      bit r = ($urandom_range(0, 199) == 0);
      bit q = REQ_RST;
      if ($urandom_range(0, 14) == 0) q = ~q;
      tick(r, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
